// File: rtl/move_display_sequencer.sv
// move_display_sequencer: move FIFO that hands moves to a cube engine and holds each on the display
module move_display_sequencer #(
    parameter int DEPTH = 8,
    parameter int DWELL = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       push,
    input  logic [2:0] push_face,
    input  logic [1:0] push_mod,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [2:0] move_face,
    output logic [1:0] move_mod,
    output logic [3:0] face_code,
    output logic [3:0] mod_code,
    output logic [4:0] count,
    output logic       full,
    output logic       empty,
    output logic       drop
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, SHOW} state_t;

    state_t        state, nxt;
    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] rptr, wptr;
    logic [CW-1:0] dwell;
    logic          pop, accept;

    assign empty = count == 5'd0;
    assign full = count == 5'(DEPTH);
    // a pop in the same cycle frees a slot, so a full queue can still take a push
    assign accept = push && push_face <= 3'd5 && push_mod <= 2'd2 && (!full || pop);
    assign face_code = state == IDLE ? 4'hA : {1'b0, move_face};
    assign mod_code = state == IDLE ? 4'hF : move_mod == 2'd0 ? 4'hB : move_mod == 2'd1 ? 4'hC : 4'hD;

    // next state, pop decision and handshake valid
    always_comb begin
        nxt = state;
        pop = 1'b0;
        move_valid = 1'b0;
        case (state)
            IDLE: begin
                pop = !empty;
                nxt = empty ? IDLE : ISSUE;
            end
            ISSUE: begin
                move_valid = 1'b1;
                nxt = move_ready ? SHOW : ISSUE;
            end
            SHOW: begin
                pop = dwell == '0 && !empty;
                nxt = dwell != '0 ? SHOW : empty ? IDLE : ISSUE;
            end
            default: nxt = IDLE;
        endcase
    end

    // queue storage write on accepted pushes
    always_ff @(posedge CLOCK_50) begin
        if (resetn && accept) mem[wptr] <= {push_face, push_mod};
    end

    // state, pointers, occupancy, current move, dwell counter and drop pulse
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state <= IDLE;
            rptr <= '0;
            wptr <= '0;
            count <= 5'd0;
            dwell <= '0;
            move_face <= 3'd0;
            move_mod <= 2'd0;
            drop <= 1'b0;
        end else begin
            state <= nxt;
            drop <= push && !accept;
            count <= count + 5'(accept) - 5'(pop);
            if (accept) wptr <= wptr + AW'(1);
            if (pop) begin
                {move_face, move_mod} <= mem[rptr];
                rptr <= rptr + AW'(1);
            end
            if (state == ISSUE && move_ready) dwell <= CW'(DWELL - 1);
            else if (state == SHOW && dwell != '0) dwell <= dwell - CW'(1);
        end
    end
endmodule

// File: tb/tb_move_display_sequencer.sv
// tb_move_display_sequencer: directed bench with an issued-move scoreboard, DEPTH=4 DWELL=4
module tb_move_display_sequencer;
    logic       clk = 1'b0;
    logic       resetn, push, move_ready;
    logic [2:0] push_face;
    logic [1:0] push_mod;
    logic       move_valid, full, empty, drop;
    logic [2:0] move_face;
    logic [1:0] move_mod;
    logic [3:0] face_code, mod_code;
    logic [4:0] count;
    logic [4:0] sbq[$];
    int         errors = 0;
    int         checks = 0;

    move_display_sequencer #(.DEPTH(4), .DWELL(4)) dut (
        .CLOCK_50(clk), .resetn(resetn), .push(push), .push_face(push_face),
        .push_mod(push_mod), .move_ready(move_ready), .move_valid(move_valid),
        .move_face(move_face), .move_mod(move_mod), .face_code(face_code),
        .mod_code(mod_code), .count(count), .full(full), .empty(empty), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input int f, input int m);
        push = p;
        push_face = 3'(f);
        push_mod = 2'(m);
    endtask

    task automatic wait_idle;
        int n = 0;
        while (!(face_code == 4'hA && empty) && n < 100) begin
            tick;
            n++;
        end
        chk("idle_timeout", 32'(n < 100), 32'd1);
    endtask

    // every completed handshake must deliver the oldest expected move
    always @(negedge clk) begin
        if (resetn && move_valid && move_ready) begin
            if (sbq.size() == 0) chk("unexpected_issue", {move_face, move_mod}, 32'hFFFF);
            else chk("issue_order", {move_face, move_mod}, sbq.pop_front());
        end
    end

    initial begin
        resetn = 1'b0;
        move_ready = 1'b0;
        drive(0, 0, 0);
        tick;
        tick;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_valid", move_valid, 0);
        chk("rst_drop", drop, 0);
        chk("rst_face_code", face_code, 4'hA);
        chk("rst_mod_code", mod_code, 4'hF);
        chk("rst_move", {move_face, move_mod}, 0);
        resetn = 1'b1;

        move_ready = 1'b1;
        drive(1, 1, 1);
        sbq.push_back({3'd1, 2'd1});
        tick;
        drive(0, 0, 0);
        chk("single_count", count, 1);
        chk("single_valid_early", move_valid, 0);
        tick;
        chk("single_valid", move_valid, 1);
        chk("single_face_issue", face_code, 4'h1);
        chk("single_mod_issue", mod_code, 4'hC);
        tick;
        for (int i = 0; i < 4; i++) begin
            chk("single_show_valid", move_valid, 0);
            chk("single_show_face", face_code, 4'h1);
            chk("single_show_mod", mod_code, 4'hC);
            tick;
        end
        chk("single_idle_face", face_code, 4'hA);
        chk("single_idle_mod", mod_code, 4'hF);
        chk("single_idle_hold", {move_face, move_mod}, {3'd1, 2'd1});

        move_ready = 1'b0;
        drive(1, 3, 2);
        sbq.push_back({3'd3, 2'd2});
        tick;
        drive(0, 0, 0);
        tick;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", move_valid, 1);
            chk("bp_move", {move_face, move_mod}, {3'd3, 2'd2});
            chk("bp_face_code", face_code, 4'h3);
            chk("bp_mod_code", mod_code, 4'hD);
            tick;
        end
        move_ready = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            chk("bp_show_valid", move_valid, 0);
            chk("bp_show_face", face_code, 4'h3);
            tick;
        end
        chk("bp_idle_face", face_code, 4'hA);

        move_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [4:0] exp_cnt [6] = '{5'd1, 5'd1, 5'd2, 5'd3, 5'd4, 5'd4};
            drive(1, i, i % 3);
            if (i < 5) sbq.push_back({3'(i), 2'(i % 3)});
            tick;
            chk("full_drop", drop, 32'(i == 5));
            chk("full_count", count, exp_cnt[i]);
            chk("full_flag", full, 32'(i >= 4));
        end
        drive(0, 0, 0);
        tick;
        chk("full_drop_end", drop, 0);
        chk("full_count_end", count, 4);
        move_ready = 1'b1;
        wait_idle;

        move_ready = 1'b0;
        drive(1, 5, 0);
        sbq.push_back({3'd5, 2'd0});
        tick;
        drive(1, 0, 2);
        sbq.push_back({3'd0, 2'd2});
        tick;
        chk("inv_pre_count", count, 1);
        drive(1, 6, 0);
        tick;
        chk("inv_face_drop", drop, 1);
        chk("inv_face_count", count, 1);
        drive(1, 2, 3);
        tick;
        chk("inv_mod_drop", drop, 1);
        chk("inv_mod_count", count, 1);
        drive(0, 0, 0);
        tick;
        chk("inv_drop_end", drop, 0);
        chk("inv_count_end", count, 1);
        move_ready = 1'b1;
        wait_idle;

        begin
            int idx = 0;
            for (int c = 1; c <= 27; c++) begin
                if (c <= 5 || (c >= 7 && (c - 7) % 5 == 0)) begin
                    drive(1, idx % 6, (idx + 1) % 3);
                    sbq.push_back({3'(idx % 6), 2'((idx + 1) % 3)});
                    idx++;
                end else drive(0, 0, 0);
                tick;
                chk("wrap_drop", drop, 0);
                chk("wrap_count", count, c == 1 ? 1 : c <= 5 ? c - 1 : 4);
            end
            chk("wrap_pushes", idx, 10);
        end
        drive(0, 0, 0);
        wait_idle;
        chk("wrap_all_issued", sbq.size(), 0);

        for (int i = 0; i < 4; i++) begin
            drive(1, i + 1, i % 3);
            sbq.push_back({3'(i + 1), 2'(i % 3)});
            tick;
        end
        chk("mid_count", count, 3);
        chk("mid_valid", move_valid, 0);
        resetn = 1'b0;
        drive(1, 2, 0);
        tick;
        sbq.delete();
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_valid", move_valid, 0);
        chk("mid_rst_drop", drop, 0);
        chk("mid_rst_face_code", face_code, 4'hA);
        chk("mid_rst_mod_code", mod_code, 4'hF);
        chk("mid_rst_move", {move_face, move_mod}, 0);
        resetn = 1'b1;
        drive(0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("post_rst_valid", move_valid, 0);
            chk("post_rst_empty", empty, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/move_display_sequencer.md
MOVE_DISPLAY_SEQUENCER -- requirements
Module: move_display_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: move-queue entries; power of two, 2..16.
REQ-002 SHALL have parameter DWELL, default 25000000: display hold time per move, in clocks; minimum 1.
REQ-003 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset; synchronous, active-low.
REQ-005 push  input  1  enqueue request, sampled each rising edge.
REQ-006 push_face  input  3  face code: 0 U, 1 R, 2 L, 3 F, 4 B, 5 D.
REQ-007 push_mod  input  2  modifier code: 0 CW, 1 CCW, 2 double.
REQ-008 move_ready  input  1  cube engine accepts the offered move.
REQ-009 move_valid  output  1  move offered to the cube engine.
REQ-010 move_face  output  3  face of the offered or shown move.
REQ-011 move_mod  output  2  modifier of the offered or shown move.
REQ-012 face_code  output  4  display-decoder select for the face digit.
REQ-013 mod_code  output  4  display-decoder select for the modifier digit.
REQ-014 count  output  5  queue occupancy.
REQ-015 full / empty  output  1 each  count==DEPTH / count==0.
REQ-016 drop  output  1  one-cycle pulse when a push is rejected.

Function
REQ-017 Queue: circular FIFO; read and write pointers wrap from DEPTH-1 to 0; count is updated in the same cycle as the pointers.
REQ-018 Push acceptance: a push SHALL be accepted iff push=1, push_face<=5, push_mod<=2, and (count<DEPTH or a pop occurs in the same cycle).
REQ-019 Rejection: any other push SHALL leave the queue unchanged and assert drop for exactly one cycle.
REQ-020 Simultaneous events: a push and a pop in the same cycle SHALL both take effect; count is unchanged, including when the queue is full.
REQ-021 FSM states: IDLE, ISSUE, SHOW.
REQ-022 IDLE: if !empty, SHALL pop the head into the current-move register and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-023 ISSUE: move_valid=1; when move_valid&&move_ready, SHALL load the dwell counter with DWELL-1 and go to SHOW; otherwise SHALL hold with move_face/move_mod stable.
REQ-024 SHOW: move_valid=0; the dwell counter decrements each cycle. At 0: if !empty, SHALL pop the next move and go to ISSUE; else SHALL go to IDLE.
REQ-025 Latency: a push accepted at edge t into an empty queue in IDLE SHALL give count=1 after t, pop at t+1, and move_valid=1 after t+1.
REQ-026 Display in ISSUE and SHOW: face_code={1'b0,move_face}; mod_code = 4'hB (CW), 4'hC (CCW), 4'hD (double).
REQ-027 Display in IDLE: face_code=4'hA ("0"); mod_code=4'hF (blank).
REQ-028 move_face/move_mod SHALL change only on a pop; they hold their last value in IDLE.
REQ-029 The dwell counter SHALL be wide enough for DWELL-1 and SHALL NOT wrap below 0.

Reset
REQ-030 While resetn=0 at an edge, after that edge: state=IDLE, pointers=0, count=0, empty=1, full=0, move_valid=0, drop=0, move_face=0, move_mod=0, face_code=4'hA, mod_code=4'hF, dwell counter=0.
REQ-031 Reset mid-operation (ISSUE or SHOW) SHALL discard all queued moves and the current move; there is no partial handshake after reset.
REQ-032 Pushes sampled while resetn=0 SHALL be ignored, with no drop pulse.

Verification (DEPTH=4, DWELL=4)
REQ-033 Single move: push face=1, mod=1 with move_ready=1 -> move_valid high one cycle, 2 cycles after the push edge; face_code=4'h1, mod_code=4'hC for 1+4 cycles; then face_code=4'hA, mod_code=4'hF.
REQ-034 Backpressure: move_ready=0 for 10 cycles -> move_valid stays 1 with move_face/move_mod stable; raising move_ready completes one transfer, then SHOW lasts 4 cycles.
REQ-035 Full/drop: 6 back-to-back pushes with move_ready=0 -> first pops, count reaches 4, full=1; 6th push gives drop=1 for one cycle; count stays 4.
REQ-036 Invalid codes: push face=6, or push mod=3 -> drop pulse; count unchanged.
REQ-037 Wrap and simultaneous events: 10 moves pushed at full rate with move_ready=1 -> all 10 are issued in push order; push+pop in the same cycle at full keeps count=4 with no drop.
REQ-038 Reset mid-SHOW: resetn=0 for one edge with 3 moves queued -> all outputs at REQ-030 values next cycle; no move_valid until a new push.
